// File: rtl/memory_stage.sv
// memory_stage: load/store alignment and write-back stage behind the execute ALU.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [7:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);
  localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h10;
  localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h11;
  localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h12;
  localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h13;
  localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h14;
  localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h18;
  localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h19;
  localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h1A;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [7:0] op;
  logic [1:0] off;
  logic accept, is_load, is_store, is_mem, bad;
  logic [3:0] strb;
  logic [31:0] wdata, ld_data;
  logic [7:0] lbyte;
  logic [15:0] lhalf;
  assign ready_out = state == IDLE;
  assign accept = valid_in && ready_out;
  assign is_load = alu_operation inside {ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW,
                                         ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU};
  assign is_store = alu_operation inside {ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW};
  assign is_mem = is_load || is_store;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bad = (alu_operation inside {ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU, ALU_OPERATIONS_SH} && alu_result[0]) ||
               (alu_operation inside {ALU_OPERATIONS_LW, ALU_OPERATIONS_SW} && |alu_result[1:0]);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nx = state == IDLE   ? (accept && is_mem ? (bad ? RESP : ACCESS) : IDLE) :
               state == ACCESS ? (mem_ack ? RESP : ACCESS) : IDLE;
    strb = alu_operation == ALU_OPERATIONS_SB ? 4'b0001 << alu_result[1:0] :
           alu_operation == ALU_OPERATIONS_SH ? (alu_result[1] ? 4'b1100 : 4'b0011) :
           alu_operation == ALU_OPERATIONS_SW ? 4'b1111 : 4'b0000;
    wdata = alu_operation == ALU_OPERATIONS_SB ? {4{store_data[7:0]}} :
            alu_operation == ALU_OPERATIONS_SH ? {2{store_data[15:0]}} : store_data;
    lbyte = mem_rdata[8*off +: 8];
    lhalf = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = op == ALU_OPERATIONS_LB  ? {{24{lbyte[7]}}, lbyte} :
              op == ALU_OPERATIONS_LBU ? {24'h0, lbyte} :
              op == ALU_OPERATIONS_LH  ? {{16{lhalf[15]}}, lhalf} :
              op == ALU_OPERATIONS_LHU ? {16'h0, lhalf} : mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      off <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      misaligned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid <= 1'b1;
        wb_we <= |rd_in;
        wb_rd <= rd_in;
        wb_data <= alu_result;
        misaligned <= 1'b0;
      end else if (accept) begin
        op <= alu_operation;
        off <= alu_result[1:0];
        wb_rd <= rd_in;
        wb_we <= 1'b0;
        mem_addr <= {alu_result[31:2], 2'b00};
        mem_we <= is_store;
        mem_wstrb <= strb;
        mem_wdata <= wdata;
        // a trapped access skips memory and reports the faulting address
        mem_req <= !bad;
        wb_valid <= bad;
        misaligned <= bad;
        if (bad) wb_data <= alu_result;
      end else if (state == ACCESS && mem_ack) begin
        mem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_we <= !mem_we && |wb_rd;
        if (!mem_we) wb_data <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: table-driven directed checks of memory_stage plus reset/stray-ack sequences.
module tb_memory_stage;
  localparam logic [7:0] ADD = 8'h00, LB = 8'h10, LH = 8'h11, LW = 8'h12, LBU = 8'h13,
                         LHU = 8'h14, SB = 8'h18, SH = 8'h19, SW = 8'h1A;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, ready_out;
  logic [7:0] alu_operation = '0;
  logic [31:0] alu_result = '0, store_data = '0, mem_addr, mem_wdata, mem_rdata = '0, wb_data;
  logic [4:0] rd_in = '0, wb_rd;
  logic mem_req, mem_we, mem_ack = 1'b0, wb_valid, wb_we, misaligned;
  logic [3:0] mem_wstrb;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] op; logic [31:0] addr, sdata; logic [4:0] rd; logic [31:0] rdata; int dly;
    logic mem, store, trap; logic [31:0] eaddr; logic [3:0] strb; logic [31:0] wdata;
    logic wbwe; logic [31:0] data;
  } vec_t;
  vec_t v[11];
  always #5 clk = ~clk;
  memory_stage dut (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .alu_operation(alu_operation), .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, sdata, input logic [4:0] rd,
      input logic [31:0] rdata, input int dly, input logic mem, store, trap, input logic [31:0] eaddr,
      input logic [3:0] strb, input logic [31:0] wdata, input logic wbwe, input logic [31:0] data);
    vec_t r;
    r.op = op; r.addr = addr; r.sdata = sdata; r.rd = rd; r.rdata = rdata; r.dly = dly;
    r.mem = mem; r.store = store; r.trap = trap; r.eaddr = eaddr; r.strb = strb; r.wdata = wdata;
    r.wbwe = wbwe; r.data = data;
    return r;
  endfunction
  // called at posedge+1 with the stage idle; leaves it idle at posedge+1
  task automatic run(input string n, input vec_t t);
    valid_in = 1'b1; alu_operation = t.op; alu_result = t.addr; store_data = t.sdata; rd_in = t.rd;
    chk({n, " ready_in_idle"}, {31'h0, ready_out}, 32'h1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (t.mem && !t.trap) begin
      for (int i = 0; i <= t.dly; i++) begin
        chk({n, " mem_req"}, {31'h0, mem_req}, 32'h1);
        chk({n, " ready_stall"}, {31'h0, ready_out}, 32'h0);
        chk({n, " mem_addr"}, mem_addr, t.eaddr);
        chk({n, " mem_we"}, {31'h0, mem_we}, {31'h0, t.store});
        chk({n, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, t.strb});
        if (t.store) chk({n, " mem_wdata"}, mem_wdata, t.wdata);
        chk({n, " no_early_wb"}, {31'h0, wb_valid}, 32'h0);
        if (i == t.dly) begin mem_ack = 1'b1; mem_rdata = t.rdata; end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
    end
    if (t.mem && t.trap) chk({n, " trap_no_req"}, {31'h0, mem_req}, 32'h0);
    chk({n, " wb_valid"}, {31'h0, wb_valid}, 32'h1);
    chk({n, " wb_we"}, {31'h0, wb_we}, {31'h0, t.wbwe});
    chk({n, " wb_rd"}, {27'h0, wb_rd}, {27'h0, t.rd});
    if (!t.store || t.trap) chk({n, " wb_data"}, wb_data, t.data);
    chk({n, " misaligned"}, {31'h0, misaligned}, {31'h0, t.trap});
    if (t.mem) begin
      chk({n, " mem_req_low"}, {31'h0, mem_req}, 32'h0);
      chk({n, " ready_resp"}, {31'h0, ready_out}, 32'h0);
      @(posedge clk); #1;
      chk({n, " wb_pulse"}, {31'h0, wb_valid}, 32'h0);
    end
  endtask
  initial begin
    logic trap_lw;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_lw = 1'b1;
`else
    trap_lw = 1'b0;
`endif
    v[0]  = mk(ADD, 32'h1234, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    v[1]  = mk(ADD, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    v[2]  = mk(LB, 32'h103, 0, 7, 32'h80FF_FF7F, 2, 1, 0, 0, 32'h100, 4'b0000, 0, 1, 32'hFFFF_FF80);
    v[3]  = mk(LBU, 32'h103, 0, 7, 32'h80FF_FF7F, 2, 1, 0, 0, 32'h100, 4'b0000, 0, 1, 32'h0000_0080);
    v[4]  = mk(SH, 32'h202, 32'hDEAD_BEEF, 3, 0, 1, 1, 1, 0, 32'h200, 4'b1100, 32'hBEEF_BEEF, 0, 0);
    v[5]  = mk(LH, 32'h102, 0, 9, 32'h80FF_1234, 0, 1, 0, 0, 32'h100, 4'b0000, 0, 1, 32'hFFFF_80FF);
    v[6]  = mk(LHU, 32'h100, 0, 9, 32'h0000_F00D, 1, 1, 0, 0, 32'h100, 4'b0000, 0, 1, 32'h0000_F00D);
    v[7]  = mk(SB, 32'h401, 32'h1234_56AB, 4, 0, 1, 1, 1, 0, 32'h400, 4'b0010, 32'hABAB_ABAB, 0, 0);
    v[8]  = trap_lw ? mk(LW, 32'h301, 0, 6, 32'hCAFE_BABE, 0, 1, 0, 1, 0, 0, 0, 0, 32'h301)
                    : mk(LW, 32'h301, 0, 6, 32'hCAFE_BABE, 0, 1, 0, 0, 32'h300, 4'b0000, 0, 1, 32'hCAFE_BABE);
    v[9]  = mk(LB, 32'h101, 0, 0, 32'h0000_7F00, 0, 1, 0, 0, 32'h100, 4'b0000, 0, 0, 32'h0000_007F);
    v[10] = mk(SH, 32'h200, 32'h0000_A5C3, 2, 0, 0, 1, 1, 0, 32'h200, 4'b0011, 32'hA5C3_A5C3, 0, 0);
    @(posedge clk); #1;
    chk("rst mem_req", {31'h0, mem_req}, 0);
    chk("rst wb_valid", {31'h0, wb_valid}, 0);
    chk("rst wb_we", {31'h0, wb_we}, 0);
    chk("rst misaligned", {31'h0, misaligned}, 0);
    chk("rst mem_wstrb", {28'h0, mem_wstrb}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst wb_data", wb_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) run($sformatf("vec%0d", i), v[i]);
    // back-to-back non-memory accepts
    valid_in = 1'b1; alu_operation = ADD; alu_result = 32'hAAAA_0001; rd_in = 1;
    @(posedge clk); #1;
    chk("b2b first", wb_data, 32'hAAAA_0001);
    alu_result = 32'hAAAA_0002; rd_in = 2;
    chk("b2b ready", {31'h0, ready_out}, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("b2b second", wb_data, 32'hAAAA_0002);
    chk("b2b valid", {31'h0, wb_valid}, 1);
    @(posedge clk); #1;
    // reset mid-ACCESS drops mem_req asynchronously
    valid_in = 1'b1; alu_operation = LW; alu_result = 32'h500; rd_in = 8;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("rstacc req", {31'h0, mem_req}, 1);
    #2 rst_n = 1'b0;
    #1 chk("rstacc async drop", {31'h0, mem_req}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("post_rst add", mk(ADD, 32'h77, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
    // stray ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray wb_valid", {31'h0, wb_valid}, 0);
    chk("stray ready", {31'h0, ready_out}, 1);
    run("sw_after_stray", mk(SW, 32'h400, 32'h1122_3344, 1, 0, 3, 1, 1, 0, 32'h400, 4'b1111,
        32'h1122_3344, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute-stage ALU. It consumes the ALU result (effective address or computed value), the store data and the destination register. It performs byte/halfword/word load-store alignment against a single-port data memory over a req/ack handshake, and delivers the write-back value to the writeback stage. Load and store operations are multi-cycle and stall execute through `ready_out`; all other operations pass through with one cycle of latency.

## Interface
- No parameters. Operation codes are the `ALU_OPERATIONS_*` encodings from the common `isa.svh` header.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: execute presents an operation.
- `ready_out` out 1: stage can accept; an operation transfers when `valid_in && ready_out`.
- `alu_operation` in 8: operation code.
- `alu_result` in 32: effective address (load/store) or result value (all other operations).
- `store_data` in 32: rs2 value for stores.
- `rd_in` in 5: destination register.
- `mem_req` out 1: memory request; held until acknowledged.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: word-aligned address (`{addr[31:2],2'b00}`).
- `mem_wstrb` out 4: byte-write enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completes the request this cycle; `mem_rdata` is valid with it.
- `mem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle pulse; the writeback fields below are valid.
- `wb_we` out 1: write `wb_data` to `wb_rd`.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: write-back value.
- `misaligned` out 1: access fault flag, qualified by `wb_valid`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `ready_out`=1.
  - On accept of a non-memory op: register `wb_data`=`alu_result` and `wb_rd`=`rd_in`; set `wb_we`=(`rd_in`!=0). Stay in IDLE.
  - On accept of a load/store: latch op, address, `store_data` and rd; go to ACCESS.
- ACCESS:
  - `ready_out`=0 and `mem_req`=1.
  - `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata`; go to RESP.
- RESP:
  - `wb_valid`=1 for this single cycle; `ready_out`=0; then return to IDLE.
  - Loads: `wb_we`=(rd!=0).
  - Stores: `wb_we`=0.
- Load extraction by `addr[1:0]`:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the halfword selected by `addr[1]`. LHU: zero-extend it.
  - LW: full word.
- Store lanes:
  - SB: `mem_wstrb`=`4'b0001<<addr[1:0]`; `mem_wdata`=byte replicated ×4.
  - SH: `mem_wstrb`=`4'b0011` or `4'b1100` by `addr[1]`; `mem_wdata`=halfword replicated ×2.
  - SW: `mem_wstrb`=`4'b1111`.
  - Loads: `mem_wstrb`=0.
- `mem_ack` outside ACCESS is ignored.
- `valid_in` while `ready_out`=0 is not accepted; execute holds its inputs.
- Reset: state IDLE. `mem_req`, `mem_we`, `mem_wstrb`, `wb_valid`, `wb_we` and `misaligned` are 0. `mem_addr`, `mem_wdata`, `wb_rd` and `wb_data` are 0.
- Reset asserted mid-ACCESS drops `mem_req` immediately and abandons the transaction.

## Timing
- Non-memory op accepted at cycle T: `wb_valid` at T+1. Back-to-back accepts are possible every cycle.
- Load/store accepted at T:
  - `mem_req` high from T+1.
  - With `mem_ack` at cycle A (A≥T+1), `wb_valid` is at A+1.
  - Next accept is possible at A+2.
  - Minimum occupancy is 3 cycles.
- All outputs are registered except `ready_out`, which decodes the state.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access is LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`!=0.
  - It issues no `mem_req` and goes straight to RESP: `wb_valid` at T+1 with `misaligned`=1, `wb_we`=0 and `wb_data`=the faulting address.
- Undefined:
  - Offending low address bits are ignored: halfword uses `addr[1]` only; word treats `addr[1:0]` as 0.
  - `misaligned` is tied 0.

## Test plan
- ADD result 0x0000_1234 with rd=5 -> `wb_valid` next cycle, `wb_data`=0x1234, `wb_we`=1. The same with rd=0 -> `wb_we`=0.
- LB at addr 0x103, `mem_rdata`=0x80FF_FF7F, ack 2 cycles after `mem_req` -> `mem_addr`=0x100, `wb_data`=0xFFFF_FF80, `wb_valid` one cycle after ack. LBU at the same address -> 0x0000_0080.
- SH at 0x202 with `store_data`=0xDEAD_BEEF -> `mem_wstrb`=`4'b1100`, `mem_wdata`=0xBEEF_BEEF, `mem_we`=1, `wb_we`=0. `ready_out`=0 until RESP completes.
- LW at 0x301 with the macro on -> no `mem_req`, `misaligned`=1, `wb_data`=0x301. With the macro off -> `mem_addr`=0x300, normal load.
- `rst_n` low while in ACCESS -> `mem_req` falls without waiting for a clock edge; after release, an ADD is accepted in the first cycle.
- `mem_ack` pulsed while IDLE, then SW at 0x400 -> the stray ack is ignored; the SW holds `mem_req` until its own ack.
